// File: rtl/lsu_request_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_request_stage
// Description : Accepts one RV32I load/store from execute, forms the effective
//               address, drives the memory_access request interface until ack,
//               waits for load data, and returns the result to the register
//               file. Reports retirement, illegal encodings and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_request_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    // execute side
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] rs2_val_i,
    input  logic [11:0] imm_i,
    input  logic [4:0]  rd_i,
    // memory_access request interface
    // memory_operation_t encoding: 2'd0 MEM_NONE, 2'd1 LOAD_DATA, 2'd2 STORE_DATA
    output logic [1:0]  memory_operation,
    output logic        cyc,
    input  logic        ack,
    input  logic        data_valid,
    output logic [2:0]  funct3,
    output logic [31:0] address,
    output logic [31:0] store_data,
    input  logic [31:0] load_data,
    // register-file write port and status
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        done_o,
    output logic        illegal_o,
    output logic        fault_o
);

    localparam logic [1:0] c_MEM_NONE   = 2'd0;
    localparam logic [1:0] c_LOAD_DATA  = 2'd1;
    localparam logic [1:0] c_STORE_DATA = 2'd2;

    localparam int              c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds N-1 during the N-th waiting cycle, so this value marks
    // the last cycle before the access is abandoned.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_WB        = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_cyc;
    logic [1:0]           r_memop;
    logic [2:0]           r_funct3;
    logic [31:0]          r_address;
    logic [31:0]          r_store_data;
    logic [4:0]           r_rd_addr;
    logic [31:0]          r_rd_data;
    logic                 r_rd_we;
    logic                 r_done;
    logic                 r_illegal;
    logic                 r_fault;

    logic                 w_legal;
    logic                 w_tmo_hit;
    logic                 w_is_store_op;
    logic [31:0]          w_eff_addr;

    assign w_eff_addr    = rs1_val_i + {{20{imm_i[11]}}, imm_i};
    assign w_tmo_hit     = (r_cnt == c_CNT_LAST);
    assign w_is_store_op = (r_memop == c_STORE_DATA);

    // Decode legality of the incoming op: exactly one of load/store, and a
    // funct3 that the chosen direction supports.
    always_comb begin
        w_legal = 1'b0;
        if (is_load_i && !is_store_i) begin
            w_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                      (funct3_i == 3'b010) || (funct3_i == 3'b100) ||
                      (funct3_i == 3'b101);
        end else if (is_store_i && !is_load_i) begin
            w_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                      (funct3_i == 3'b010);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ack/data_valid are checked before the timeout so a
    // completion in the final allowed cycle still retires normally.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_next_state = w_legal ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (ack) begin
                    if (w_is_store_op) begin
                        w_next_state = S_DONE;
                    end else if (data_valid) begin
                        w_next_state = S_WB;
                    end else begin
                        w_next_state = S_LOAD_WAIT;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD_WAIT: begin
                if (data_valid) begin
                    w_next_state = S_WB;
                end else if (w_tmo_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WB:    w_next_state = S_IDLE;
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs: operand latching, request handshake,
    // timeout counting and the single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_cyc        <= 1'b0;
            r_memop      <= c_MEM_NONE;
            r_funct3     <= 3'b000;
            r_address    <= 32'h0;
            r_store_data <= 32'h0;
            r_rd_addr    <= 5'd0;
            r_rd_data    <= 32'h0;
            r_rd_we      <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_rd_we   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_funct3     <= funct3_i;
                        r_address    <= w_eff_addr;
                        r_store_data <= rs2_val_i;
                        r_rd_addr    <= rd_i;
                        if (w_legal) begin
                            r_cyc   <= 1'b1;
                            r_memop <= is_load_i ? c_LOAD_DATA : c_STORE_DATA;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        r_cyc   <= 1'b0;
                        r_memop <= c_MEM_NONE;
                        if (!w_is_store_op && data_valid) begin
                            r_rd_data <= load_data;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_tmo_hit) begin
                        r_cyc   <= 1'b0;
                        r_memop <= c_MEM_NONE;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD_WAIT: begin
                    if (data_valid) begin
                        r_rd_data <= load_data;
                    end else if (w_tmo_hit) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    r_rd_we <= (r_rd_addr != 5'd0);
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                S_ERR: begin
                    r_illegal <= 1'b1;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_memop <= c_MEM_NONE;
                end
            endcase
        end
    end

    assign ready_o          = (r_state == S_IDLE);
    assign cyc              = r_cyc;
    assign memory_operation = r_memop;
    assign funct3           = r_funct3;
    assign address          = r_address;
    assign store_data       = r_store_data;
    assign rd_addr_o        = r_rd_addr;
    assign rd_data_o        = r_rd_data;
    assign rd_we_o          = r_rd_we;
    assign done_o           = r_done;
    assign illegal_o        = r_illegal;
    assign fault_o          = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lsu_request_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_request_stage
// Description : Directed self-checking bench for lsu_request_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_request_stage;

    localparam logic [1:0] c_MEM_NONE   = 2'd0;
    localparam logic [1:0] c_LOAD_DATA  = 2'd1;
    localparam logic [1:0] c_STORE_DATA = 2'd2;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic [11:0] imm_i;
    logic [4:0]  rd_i;
    logic [1:0]  memory_operation;
    logic        cyc;
    logic        ack;
    logic        data_valid;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        done_o;
    logic        illegal_o;
    logic        fault_o;

    int checks;
    int errors;

    lsu_request_stage #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .is_load_i        (is_load_i),
        .is_store_i       (is_store_i),
        .funct3_i         (funct3_i),
        .rs1_val_i        (rs1_val_i),
        .rs2_val_i        (rs2_val_i),
        .imm_i            (imm_i),
        .rd_i             (rd_i),
        .memory_operation (memory_operation),
        .cyc              (cyc),
        .ack              (ack),
        .data_valid       (data_valid),
        .funct3           (funct3),
        .address          (address),
        .store_data       (store_data),
        .load_data        (load_data),
        .rd_we_o          (rd_we_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o),
        .done_o           (done_o),
        .illegal_o        (illegal_o),
        .fault_o          (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i    = 1'b0;
        is_load_i  = 1'b0;
        is_store_i = 1'b0;
        funct3_i   = 3'b000;
        rs1_val_i  = 32'h0;
        rs2_val_i  = 32'h0;
        imm_i      = 12'h0;
        rd_i       = 5'd0;
        ack        = 1'b0;
        data_valid = 1'b0;
        load_data  = 32'h0;
    endtask

    // Present one instruction for a single accept cycle.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [11:0] imm,
                         input logic [31:0] rs2, input logic [4:0] rd);
        valid_i    = 1'b1;
        is_load_i  = ld;
        is_store_i = st;
        funct3_i   = f3;
        rs1_val_i  = rs1;
        imm_i      = imm;
        rs2_val_i  = rs2;
        rd_i       = rd;
        tick();
        valid_i    = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        valid_i = 1'b1;
        is_load_i = 1'b1;
        tick();
        tick();
        checks++;
        if (ready_o !== 1'b1 || cyc !== 1'b0 || memory_operation !== c_MEM_NONE) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b cyc=%b op=%0d, expected ready=1 cyc=0 op=0", ready_o, cyc, memory_operation);
        end
        checks++;
        if (address !== 32'h0 || store_data !== 32'h0 || rd_data_o !== 32'h0 ||
            rd_addr_o !== 5'd0 || funct3 !== 3'b000) begin
            errors++;
            $display("FAIL reset_data: addr=%h sd=%h rdd=%h rda=%0d f3=%b, expected all zero", address, store_data, rd_data_o, rd_addr_o, funct3);
        end
        checks++;
        if (rd_we_o !== 1'b0 || done_o !== 1'b0 || illegal_o !== 1'b0 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: we=%b done=%b ill=%b flt=%b, expected 0", rd_we_o, done_o, illegal_o, fault_o);
        end
        clear_inputs();
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_1000, 12'hFFC, 32'h0, 5'd5);
        checks++;
        if (cyc !== 1'b1 || memory_operation !== c_LOAD_DATA || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_req: cyc=%b op=%0d ready=%b, expected cyc=1 op=1 ready=0", cyc, memory_operation, ready_o);
        end
        checks++;
        if (address !== 32'h0000_0FFC || funct3 !== 3'b010) begin
            errors++;
            $display("FAIL lw_addr: addr=%h f3=%b, expected 00000ffc 010", address, funct3);
        end
        tick();
        checks++;
        if (cyc !== 1'b1 || address !== 32'h0000_0FFC) begin
            errors++;
            $display("FAIL lw_hold: cyc=%b addr=%h, expected 1 00000ffc", cyc, address);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (cyc !== 1'b0 || memory_operation !== c_MEM_NONE || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_ack: cyc=%b op=%0d ready=%b, expected 0 0 0", cyc, memory_operation, ready_o);
        end
        tick();
        data_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        data_valid = 1'b0;
        load_data  = 32'h0;
        checks++;
        if (rd_we_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb_early: we=%b done=%b, expected 0 0", rd_we_o, done_o);
        end
        tick();
        checks++;
        if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hDEAD_BEEF || done_o !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb: we=%b rda=%0d rdd=%h done=%b, expected 1 5 deadbeef 1", rd_we_o, rd_addr_o, rd_data_o, done_o);
        end
        tick();
        checks++;
        if (rd_we_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lw_after: we=%b done=%b ready=%b, expected 0 0 1", rd_we_o, done_o, ready_o);
        end
    endtask

    task automatic test_sb();
        logic we_seen;
        we_seen = 1'b0;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_2003, 12'h000, 32'h0000_0055, 5'd7);
        checks++;
        if (cyc !== 1'b1 || memory_operation !== c_STORE_DATA || funct3 !== 3'b000 ||
            store_data !== 32'h55 || address !== 32'h0000_2003) begin
            errors++;
            $display("FAIL sb_req: cyc=%b op=%0d f3=%b sd=%h addr=%h, expected 1 2 000 00000055 00002003", cyc, memory_operation, funct3, store_data, address);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        we_seen = we_seen | rd_we_o;
        checks++;
        if (cyc !== 1'b0 || memory_operation !== c_MEM_NONE) begin
            errors++;
            $display("FAIL sb_ack: cyc=%b op=%0d, expected 0 0", cyc, memory_operation);
        end
        tick();
        we_seen = we_seen | rd_we_o;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL sb_done: done=%b, expected 1", done_o);
        end
        tick();
        we_seen = we_seen | rd_we_o;
        checks++;
        if (we_seen !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_nowrite: we_seen=%b done=%b, expected 0 0", we_seen, done_o);
        end
    endtask

    task automatic test_lbu_rd0_latency();
        int  lat;
        logic we_seen;
        we_seen = 1'b0;
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0040, 12'h004, 32'h0, 5'd0);
        lat = 1;
        ack        = 1'b1;
        data_valid = 1'b1;
        load_data  = 32'h0000_007F;
        while (done_o !== 1'b1 && lat < 10) begin
            tick();
            ack        = 1'b0;
            data_valid = 1'b0;
            lat++;
            we_seen = we_seen | rd_we_o;
        end
        checks++;
        if (done_o !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL lbu_latency: done=%b latency=%0d, expected done=1 latency=3", done_o, lat);
        end
        checks++;
        if (we_seen !== 1'b0 || rd_data_o !== 32'h7F || address !== 32'h44) begin
            errors++;
            $display("FAIL lbu_rd0: we_seen=%b rdd=%h addr=%h, expected 0 0000007f 00000044", we_seen, rd_data_o, address);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [2:0]  f3_v [3];
        logic        ld_v [3];
        logic        st_v [3];
        f3_v = '{3'b011, 3'b010, 3'b000};
        ld_v = '{1'b1,   1'b1,   1'b0};
        st_v = '{1'b0,   1'b1,   1'b0};
        for (int k = 0; k < 3; k++) begin
            logic cyc_seen;
            issue(ld_v[k], st_v[k], f3_v[k], 32'h100, 12'h0, 32'h0, 5'd9);
            cyc_seen = cyc;
            checks++;
            if (illegal_o !== 1'b0 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_err_state[%0d]: ill=%b ready=%b, expected 0 0", k, illegal_o, ready_o);
            end
            tick();
            cyc_seen = cyc_seen | cyc;
            checks++;
            if (illegal_o !== 1'b1 || ready_o !== 1'b1 || cyc_seen !== 1'b0 || rd_we_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse[%0d]: ill=%b ready=%b cyc_seen=%b we=%b, expected 1 1 0 0", k, illegal_o, ready_o, cyc_seen, rd_we_o);
            end
            tick();
            checks++;
            if (illegal_o !== 1'b0 || cyc !== 1'b0) begin
                errors++;
                $display("FAIL illegal_end[%0d]: ill=%b cyc=%b, expected 0 0", k, illegal_o, cyc);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b1, 1'b0, 3'b010, 32'h300, 12'h0, 32'h0, 5'd4);
        n = 0;
        while (cyc === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8 || fault_o !== 1'b1 || cyc !== 1'b0) begin
            errors++;
            $display("FAIL timeout: req_cycles=%0d fault=%b cyc=%b, expected 8 1 0", n, fault_o, cyc);
        end
        checks++;
        if (rd_we_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_nowrite: we=%b done=%b ready=%b, expected 0 0 1", rd_we_o, done_o, ready_o);
        end
        tick();
        checks++;
        if (fault_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: fault=%b, expected 0", fault_o);
        end
    endtask

    task automatic test_ack_last_cycle();
        logic flt_seen;
        flt_seen = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h400, 12'h0, 32'h0, 5'd3);
        for (int i = 0; i < 7; i++) begin
            tick();
            flt_seen = flt_seen | fault_o;
        end
        checks++;
        if (cyc !== 1'b1) begin
            errors++;
            $display("FAIL ack8_still_req: cyc=%b, expected 1", cyc);
        end
        ack        = 1'b1;
        data_valid = 1'b1;
        load_data  = 32'h1234_5678;
        tick();
        ack        = 1'b0;
        data_valid = 1'b0;
        flt_seen = flt_seen | fault_o;
        tick();
        flt_seen = flt_seen | fault_o;
        checks++;
        if (flt_seen !== 1'b0 || done_o !== 1'b1 || rd_we_o !== 1'b1 || rd_data_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ack8: fault_seen=%b done=%b we=%b rdd=%h, expected 0 1 1 12345678", flt_seen, done_o, rd_we_o, rd_data_o);
        end
        tick();
    endtask

    task automatic test_wrap();
        issue(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFF, 12'h001, 32'h0, 5'd1);
        checks++;
        if (address !== 32'h0000_0000 || cyc !== 1'b1) begin
            errors++;
            $display("FAIL addr_wrap: addr=%h cyc=%b, expected 00000000 1", address, cyc);
        end
        ack        = 1'b1;
        data_valid = 1'b1;
        tick();
        ack        = 1'b0;
        data_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic pulse_seen;
        issue(1'b1, 1'b0, 3'b010, 32'h500, 12'h0, 32'h0, 5'd6);
        checks++;
        if (cyc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: cyc=%b, expected 1", cyc);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || ready_o !== 1'b1 || memory_operation !== c_MEM_NONE) begin
            errors++;
            $display("FAIL rstmid_async: cyc=%b ready=%b op=%0d, expected 0 1 0", cyc, ready_o, memory_operation);
        end
        tick();
        pulse_seen = done_o | rd_we_o;
        rst = 1'b1;
        tick();
        pulse_seen = pulse_seen | done_o | rd_we_o;
        checks++;
        if (pulse_seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nopulse: pulse_seen=%b, expected 0", pulse_seen);
        end
        issue(1'b1, 1'b0, 3'b010, 32'h0000_1000, 12'hFFC, 32'h0, 5'd5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        data_valid = 1'b1;
        load_data  = 32'hCAFE_F00D;
        tick();
        data_valid = 1'b0;
        tick();
        checks++;
        if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'hCAFE_F00D || done_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: we=%b rda=%0d rdd=%h done=%b, expected 1 5 cafef00d 1", rd_we_o, rd_addr_o, rd_data_o, done_o);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_sb();
        test_lbu_rd0_latency();
        test_illegal();
        test_timeout();
        test_ack_last_cycle();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
